fifo_share_arbiter: RTL and testbench
=====================================

FIFO_SHARE_ARBITER -- requirements
Module: fifo_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of producer ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, beat width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, capacity of the shared downstream FIFO.
REQ-004 SHALL have parameter BURST_LEN, default 4, maximum consecutive beats per grant (used only with burst feature).
REQ-005 SHALL have ports:
  clk  input  1  clock, all state on rising edge
  rst  input  1  asynchronous, active-low reset
  req_valid  input  N_REQ  per-producer beat valid
  req_data  input  N_REQ*DATA_W  per-producer beat, port i at bits [i*DATA_W +: DATA_W]
  req_ready  output  N_REQ  per-producer accept
  fifo_full  input  1  full flag from shared FIFO
  fifo_enr  input  1  consumer read strobe on shared FIFO
  fifo_enw  output  1  write strobe to shared FIFO
  fifo_datain  output  DATA_W  write data to shared FIFO
  grant_id  output  clog2(N_REQ)  index of producer whose beat is on fifo_datain
  occupancy  output  clog2(DEPTH+1)  tracked shared-FIFO fill level

Function
REQ-006 Beat accepted on port i SHALL mean req_valid[i] & req_ready[i] in the same cycle.
REQ-007 At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid and registered state.
REQ-008 Winner SHALL be the first port with req_valid high, searching round-robin from last_grant+1 modulo N_REQ.
REQ-009 req_ready[winner] SHALL be high only if fifo_full==0 and occupancy + fifo_enw < DEPTH (reserve for in-flight write).
REQ-010 Accepted beat SHALL appear one cycle later: fifo_enw=1, fifo_datain=beat, grant_id=i; otherwise fifo_enw=0, fifo_datain and grant_id hold.
REQ-011 last_grant SHALL update to i on every accepted beat (non-burst mode).
REQ-012 occupancy SHALL: +1 on fifo_enw only; -1 on fifo_enr only when occupancy>0; unchanged on both or neither; fifo_enr at 0 ignored.
REQ-013 occupancy SHALL saturate at DEPTH; never wrap in either direction.
REQ-014 No req_valid high -> no req_ready, last_grant unchanged.
REQ-015 fifo_full high SHALL block all acceptance that cycle regardless of occupancy.

Reset
REQ-016 On rst low: fifo_enw=0, fifo_datain=0, grant_id=0, occupancy=0, last_grant=N_REQ-1 (port 0 highest priority), burst count=0.
REQ-017 Reset mid-beat SHALL drop the in-flight write; no fifo_enw in the first cycle after release.

Configuration
REQ-018 Macro FIFO_ARB_BURST_EN defined: current winner SHALL keep priority while its req_valid stays high, up to BURST_LEN accepted beats, then last_grant advances; a deasserted valid or stall-free hand-off ends the burst early.
REQ-019 Macro undefined: strict per-beat round-robin, BURST_LEN ignored, no burst counter synthesized.

Structure
REQ-020 Package fifo_arb_pkg SHALL hold default N_REQ/DATA_W/DEPTH/BURST_LEN constants and the index-width function.
REQ-021 Round-robin winner search SHALL be sub-module rr_pick (inputs req vector and last_grant, output winner index and any-valid).

Verification
REQ-022 Reset, ports 0 and 2 valid constantly, no reads -> grants 0,2,0,2; occupancy 1,2,3,4.
REQ-023 All 4 ports valid, occupancy reaches 64 -> all req_ready low; one fifo_enr -> occupancy 63, next grant follows round-robin order.
REQ-024 fifo_enw and fifo_enr same cycle at occupancy 10 -> occupancy stays 10; fifo_enr at 0 -> stays 0.
REQ-025 fifo_full forced high at occupancy 5 -> no acceptance, fifo_enw=0 next cycle.
REQ-026 FIFO_ARB_BURST_EN, BURST_LEN=4, ports 1 and 3 valid -> grants 1,1,1,1,3,3,3,3; without macro -> 1,3,1,3.
REQ-027 rst low during accepted beat -> fifo_enw=0 after release, occupancy 0, next grant to lowest valid port.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and index-width helper for the shared-FIFO arbiter.
package fifo_arb_pkg;

   localparam int unsigned DEF_N_REQ     = 4;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_DEPTH     = 64;
   localparam int unsigned DEF_BURST_LEN = 4;

   // Bits needed to index n items; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request starting after last_grant.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned N_REQ = DEF_N_REQ,
   localparam int unsigned IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [IW-1:0]    winner,
   output logic             any_valid
);

   // Walk offsets from farthest to nearest so the nearest valid port wins.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      winner    = last_grant;
      any_valid = |req;
      for (int unsigned k = N_REQ; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (req[idx]) winner = IW'(idx);
      end
   end

endmodule

// File: rtl/fifo_share_arbiter.sv
// N-producer round-robin arbiter feeding one shared FIFO with occupancy tracking.
// Define FIFO_ARB_BURST_EN to let a winner keep priority for up to BURST_LEN beats.
module fifo_share_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned N_REQ     = DEF_N_REQ,
   parameter  int unsigned DATA_W    = DEF_DATA_W,
   parameter  int unsigned DEPTH     = DEF_DEPTH,
   parameter  int unsigned BURST_LEN = DEF_BURST_LEN,
   localparam int unsigned IW        = idx_w(N_REQ),
   localparam int unsigned OW        = idx_w(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    fifo_full,
   input  logic                    fifo_enr,
   output logic                    fifo_enw,
   output logic [DATA_W-1:0]       fifo_datain,
   output logic [IW-1:0]           grant_id,
   output logic [OW-1:0]           occupancy
);

   if (N_REQ < 2 || N_REQ > 8 || DEPTH < 1 || BURST_LEN < 1) begin : g_param_err
      $error("fifo_share_arbiter: illegal parameter set");
   end

   logic [IW-1:0]     last_grant;
   logic [IW-1:0]     rr_winner;
   logic [IW-1:0]     winner;
   logic              any_valid;
   logic              room;
   logic              accept;
   logic              occ_inc;
   logic              occ_dec;
   logic [DATA_W-1:0] sel_data;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .winner     (rr_winner),
      .any_valid  (any_valid)
   );

`ifdef FIFO_ARB_BURST_EN
   localparam int unsigned BW = idx_w(BURST_LEN + 1);

   logic [BW-1:0] burst_cnt;
   logic          hold;

   // Previous winner keeps the grant while it stays valid and has beats left.
   assign hold   = (burst_cnt != '0) && (burst_cnt < BW'(BURST_LEN)) && req_valid[last_grant];
   assign winner = hold ? last_grant : rr_winner;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt <= '0;
      end else if (accept) begin
         burst_cnt <= hold ? burst_cnt + BW'(1) : BW'(1);
      end else if (!req_valid[last_grant]) begin
         burst_cnt <= '0;
      end
   end
`else
   assign winner = rr_winner;
`endif

   // One slot is held back for a write already on its way into the FIFO.
   assign room   = !fifo_full &&
                   (({1'b0, occupancy} + (OW+1)'(fifo_enw)) < (OW+1)'(DEPTH));
   assign accept = any_valid && room;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (winner == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_enw    <= 1'b0;
         fifo_datain <= '0;
         grant_id    <= '0;
         last_grant  <= IW'(N_REQ - 1);
      end else begin
         fifo_enw <= accept;
         if (accept) begin
            fifo_datain <= sel_data;
            grant_id    <= winner;
            last_grant  <= winner;
         end
      end
   end

   assign occ_inc = fifo_enw;
   assign occ_dec = fifo_enr && (occupancy != '0);

   // Saturating fill-level tracker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occupancy <= '0;
      end else if (occ_inc && !occ_dec) begin
         if (occupancy < OW'(DEPTH)) occupancy <= occupancy + OW'(1);
      end else if (occ_dec && !occ_inc) begin
         occupancy <= occupancy - OW'(1);
      end
   end

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Directed self-checking bench for fifo_share_arbiter (default parameters).
module tb_fifo_share_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_enr;
   logic        fifo_enw;
   logic [7:0]  fifo_datain;
   logic [1:0]  grant_id;
   logic [6:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   fifo_share_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_enr    (fifo_enr),
      .fifo_enw    (fifo_enw),
      .fifo_datain (fifo_datain),
      .grant_id    (grant_id),
      .occupancy   (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] exp_g22 [4];
      logic [7:0] exp_d22 [4];
      logic [1:0] exp_g26 [8];
      int  fill_beats;
      bit  stopped;

`ifdef FIFO_ARB_BURST_EN
      exp_g22 = '{2'd0, 2'd0, 2'd0, 2'd0};
      exp_d22 = '{8'hA0, 8'hA0, 8'hA0, 8'hA0};
      exp_g26 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
`else
      exp_g22 = '{2'd0, 2'd2, 2'd0, 2'd2};
      exp_d22 = '{8'hA0, 8'hC2, 8'hA0, 8'hC2};
      exp_g26 = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
`endif

      rst       = 1'b0;
      req_valid = 4'b0000;
      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      fifo_full = 1'b0;
      fifo_enr  = 1'b0;
      repeat (2) tick();
      check("rst_enw", 32'(fifo_enw), 32'd0);
      check("rst_datain", 32'(fifo_datain), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b1;
      tick();
      check("idle_enw", 32'(fifo_enw), 32'd0);

      // Ports 0 and 2 valid, no reads.
      req_valid = 4'b0101;
      #1;
      check("rr_first_ready", 32'(req_ready), 32'b0001);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr_grant%0d", i), 32'(grant_id), 32'(exp_g22[i]));
         check($sformatf("rr_data%0d", i), 32'(fifo_datain), 32'(exp_d22[i]));
         check($sformatf("rr_enw%0d", i), 32'(fifo_enw), 32'd1);
         check($sformatf("rr_occ%0d", i), 32'(occupancy), 32'(i));
      end
      req_valid = 4'b0000;
      tick();
      check("rr_occ_final", 32'(occupancy), 32'd4);
      check("rr_enw_idle", 32'(fifo_enw), 32'd0);

      // Bring occupancy to 10, then write and read in the same cycle.
      req_valid = 4'b0001;
      repeat (6) tick();
      req_valid = 4'b0000;
      tick();
      check("fill10_occ", 32'(occupancy), 32'd10);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      fifo_enr  = 1'b1;
      tick();
      fifo_enr  = 1'b0;
      check("wr_rd_same_occ", 32'(occupancy), 32'd10);

      // Drain to 5, then hold fifo_full.
      fifo_enr = 1'b1;
      repeat (5) tick();
      fifo_enr = 1'b0;
      check("drain5_occ", 32'(occupancy), 32'd5);
      fifo_full = 1'b1;
      req_valid = 4'b1111;
      #1;
      check("full_ready", 32'(req_ready), 32'd0);
      tick();
      check("full_enw", 32'(fifo_enw), 32'd0);
      check("full_occ", 32'(occupancy), 32'd5);
      fifo_full = 1'b0;
      #1;

      // All ports valid until the reservation check blocks acceptance.
      fill_beats = 0;
      stopped    = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (req_ready == 4'b0000) begin
            stopped = 1'b1;
            break;
         end
         tick();
         fill_beats++;
      end
      check("fill_stopped", 32'(stopped), 32'd1);
      check("fill_beats", 32'(fill_beats), 32'd59);
`ifndef FIFO_ARB_BURST_EN
      check("fill_last_grant", 32'(grant_id), 32'd3);
`endif
      tick();
      check("full64_occ", 32'(occupancy), 32'd64);
      check("full64_ready", 32'(req_ready), 32'd0);
      check("full64_enw", 32'(fifo_enw), 32'd0);
      fifo_enr = 1'b1;
      tick();
      fifo_enr = 1'b0;
      #1;
      check("read63_occ", 32'(occupancy), 32'd63);
`ifndef FIFO_ARB_BURST_EN
      check("read63_ready", 32'(req_ready), 32'b0001);
      tick();
      check("read63_grant", 32'(grant_id), 32'd0);
      check("read63_data", 32'(fifo_datain), 32'hA0);
`else
      tick();
`endif
      check("read63_enw", 32'(fifo_enw), 32'd1);
      check("refill_block", 32'(req_ready), 32'd0);

      // Drain well past empty; reads at zero are ignored.
      req_valid = 4'b0000;
      fifo_enr  = 1'b1;
      repeat (70) tick();
      fifo_enr  = 1'b0;
      check("empty_occ", 32'(occupancy), 32'd0);
      tick();
      check("empty_hold", 32'(occupancy), 32'd0);

      // Ports 1 and 3 valid.
      req_valid = 4'b1010;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("p13_grant%0d", i), 32'(grant_id), 32'(exp_g26[i]));
      end
      req_valid = 4'b0000;
      tick();

      // Reset asserted while a beat is being accepted.
      req_valid = 4'b0110;
      #1;
      check("pre_rst_ready", 32'(req_ready), 32'b0010);
      #2;
      rst = 1'b0;
      tick();
      check("mid_rst_enw", 32'(fifo_enw), 32'd0);
      check("mid_rst_occ", 32'(occupancy), 32'd0);
      rst = 1'b1;
      #1;
      check("post_rst_enw", 32'(fifo_enw), 32'd0);
      tick();
      check("post_rst_grant", 32'(grant_id), 32'd1);
      check("post_rst_data", 32'(fifo_datain), 32'hB1);
      check("post_rst_wr", 32'(fifo_enw), 32'd1);
      req_valid = 4'b0000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
